dlatch_wr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one dlatch4-style W-bit transparent latch bank between NREQ requesters.
- Grants one requester at a time.
- Registers that requester's data and drives it onto the latch D inputs.
- Sequences the latch enable with guaranteed setup and hold margins.
- Signals completion back to the requester.
- Sits between requester logic and the latch bank, which is its sole driver.

---
 rtl/dlatch_ctrl_pkg.sv | 28 ++
 rtl/dlatch_wr_arbiter_rr_pick.sv | 43 ++++
 rtl/dlatch_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dlatch_wr_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dlatch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dlatch_ctrl_pkg
// Shared types and defaults for the latch-bank write arbiter.
//   state_e      : sequencer states, 3-bit encoding
//   DEF_*        : default parameter values for dlatch_wr_arbiter
//   max_int()    : elaboration-time helper for sizing the phase counter
// No ports (package).
// -----------------------------------------------------------------------------
package dlatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_W         = 4;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_EN_CYC    = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dlatch_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches last+1, last+2, ... (mod NREQ)
// and returns the first requester whose request bit is set.
// Ports:
//   req_i  [NREQ-1:0] request vector
//   last_i [IW-1:0]   index of the most recently granted requester
//   sel_o  [NREQ-1:0] one-hot selection (all zero when nothing requests)
//   idx_o  [IW-1:0]   binary index of the selection
//   vld_o             a requester was selected
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] sel_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);

  always_comb begin
    int  j;
    logic found;
    sel_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    // k starts at 1 so the last winner is checked last: strict rotation.
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[IW'(j)]) begin
        found          = 1'b1;
        sel_o[IW'(j)]  = 1'b1;
        idx_o          = IW'(j);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/dlatch_wr_arbiter.sv
// -----------------------------------------------------------------------------
// dlatch_wr_arbiter
// Round-robin arbiter and write sequencer that is the sole driver of a shared
// W-bit transparent latch bank. One requester is granted at a time; its data
// is captured at grant, driven on D_out, and En_out is pulsed with SETUP_CYC
// cycles of setup before and one cycle of hold after the enable window.
// Sequence after grant: SETUP (SETUP_CYC) -> ENABLE (EN_CYC) -> HOLD (1)
// -> DONE (1) -> IDLE, so Done arrives SETUP_CYC+EN_CYC+1 cycles after Gnt.
//
// Ports:
//   Clk     in   clock, rising edge
//   Rst     in   asynchronous active-high reset
//   Req     in   [NREQ]   per-requester level write request
//   Data    in   [NREQ*W] requester i data in bits [i*W +: W]
//   Gnt     out  [NREQ]   one-hot grant, held from grant through DONE
//   Done    out  [NREQ]   one-cycle completion pulse to the granted requester
//   D_out   out  [W]      latch D
//   En_out  out           latch En (registered, glitch-free)
//   Q_in    in   [W]      latch Q readback
//   Busy    out           high whenever the sequencer is not IDLE
//   Err     out           readback mismatch pulse, coincident with Done
//
// Build option: define READBACK_CHECK_EN to compare Q_in against the written
// data during HOLD and flag a mismatch on Err. Without it Err is tied low and
// Q_in is ignored.
// -----------------------------------------------------------------------------
module dlatch_wr_arbiter
  import dlatch_ctrl_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int W         = DEF_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EN_CYC    = DEF_EN_CYC
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [NREQ-1:0] Req,
  input  logic [NREQ*W-1:0] Data,
  output logic [NREQ-1:0] Gnt,
  output logic [NREQ-1:0] Done,
  output logic [W-1:0]    D_out,
  output logic            En_out,
  input  logic [W-1:0]    Q_in,
  output logic            Busy,
  output logic            Err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(max_int(SETUP_CYC, EN_CYC) + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     last_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic [W-1:0]      data_q;
  logic              en_q;

  logic [NREQ-1:0]   pick_sel;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic              grant_now;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i  (Req),
    .last_i (last_q),
    .sel_o  (pick_sel),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  assign grant_now = (state_q == ST_IDLE) && pick_vld;

  // Next-state and phase counter. The counter is reloaded on every state
  // entry with (dwell - 1) and the state advances when it reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ENABLE;
          cnt_d   = CW'(EN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ENABLE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_DONE;
        cnt_d   = '0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so En_out and Done change
  // exactly on state boundaries with no combinational decode behind them.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d == ST_ENABLE);
      done_q  <= (state_d == ST_DONE) ? gnt_q : '0;
      if (grant_now) begin
        gnt_q  <= pick_sel;
        last_q <= pick_idx;
        // Data is sampled only here; later changes on Data are ignored.
        data_q <= Data[int'(pick_idx)*W +: W];
      end else if (state_d == ST_IDLE) begin
        gnt_q <= '0;
      end
    end
  end

`ifdef READBACK_CHECK_EN
  logic err_q;

  // HOLD is always followed by DONE, so a mismatch seen in HOLD lands on Err
  // in the same cycle as Done.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == ST_HOLD) && (Q_in != data_q);
    end
  end

  assign Err = err_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^Q_in;
  assign Err         = 1'b0;
`endif

  assign Gnt    = gnt_q;
  assign Done   = done_q;
  assign D_out  = data_q;
  assign En_out = en_q;
  assign Busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dlatch_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dlatch_wr_arbiter
// Directed bench for dlatch_wr_arbiter with default parameters and a simple
// behavioural latch on D_out/En_out feeding Q_in.
// -----------------------------------------------------------------------------
module tb_dlatch_wr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic            Clk;
  logic            Rst;
  logic [NREQ-1:0] Req;
  logic [NREQ*W-1:0] Data;
  logic [NREQ-1:0] Gnt;
  logic [NREQ-1:0] Done;
  logic [W-1:0]    D_out;
  logic            En_out;
  logic [W-1:0]    Q_in;
  logic            Busy;
  logic            Err;

  logic [W-1:0]    q_lat;
  logic            stuck;

  int n_checks;
  int n_errors;

  dlatch_wr_arbiter #(
    .NREQ      (NREQ),
    .W         (W),
    .SETUP_CYC (1),
    .EN_CYC    (2)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Req    (Req),
    .Data   (Data),
    .Gnt    (Gnt),
    .Done   (Done),
    .D_out  (D_out),
    .En_out (En_out),
    .Q_in   (Q_in),
    .Busy   (Busy),
    .Err    (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Transparent latch model; 'stuck' forces its Q to zero.
  initial q_lat = '0;
  always @(En_out or D_out) if (En_out) q_lat = D_out;
  assign Q_in = stuck ? '0 : q_lat;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge with Req/Data already set so the grant happens on the
  // next posedge. Walks c1..c5 (SETUP, ENABLE, ENABLE, HOLD, DONE) and returns
  // at the DONE negedge. action 1: Data[1] -> 9 after c1; action 2: drop
  // Req[2] after c2.
  task automatic txn(input string tag, input logic [NREQ-1:0] g, input logic [W-1:0] d,
                     input logic e, input int action);
    @(negedge Clk);
    chk({tag, ".c1.gnt"},  Gnt,    g);
    chk({tag, ".c1.en"},   En_out, 1'b0);
    chk({tag, ".c1.d"},    D_out,  d);
    chk({tag, ".c1.busy"}, Busy,   1'b1);
    chk({tag, ".c1.done"}, Done,   '0);
    if (action == 1) Data[1*W +: W] = 4'h9;
    @(negedge Clk);
    chk({tag, ".c2.en"}, En_out, 1'b1);
    if (action == 2) Req[2] = 1'b0;
    @(negedge Clk);
    chk({tag, ".c3.en"}, En_out, 1'b1);
    chk({tag, ".c3.d"},  D_out,  d);
    @(negedge Clk);
    chk({tag, ".c4.en"}, En_out, 1'b0);
    chk({tag, ".c4.d"},  D_out,  d);
    chk({tag, ".c4.done"}, Done, '0);
    @(negedge Clk);
    chk({tag, ".c5.done"}, Done,   g);
    chk({tag, ".c5.gnt"},  Gnt,    g);
    chk({tag, ".c5.en"},   En_out, 1'b0);
    chk({tag, ".c5.err"},  Err,    e);
  endtask

  task automatic idle_chk(input string tag, input logic [W-1:0] d);
    @(negedge Clk);
    chk({tag, ".idle.gnt"},  Gnt,    '0);
    chk({tag, ".idle.busy"}, Busy,   1'b0);
    chk({tag, ".idle.done"}, Done,   '0);
    chk({tag, ".idle.en"},   En_out, 1'b0);
    chk({tag, ".idle.d"},    D_out,  d);
  endtask

  logic exp_stuck_err;

  initial begin
    n_checks = 0;
    n_errors = 0;
    stuck    = 1'b0;
`ifdef READBACK_CHECK_EN
    exp_stuck_err = 1'b1;
`else
    exp_stuck_err = 1'b0;
`endif
    Rst  = 1'b1;
    Req  = '0;
    Data = '0;

    // Reset state
    @(negedge Clk);
    chk("rst.gnt",  Gnt,    '0);
    chk("rst.done", Done,   '0);
    chk("rst.en",   En_out, 1'b0);
    chk("rst.d",    D_out,  '0);
    chk("rst.busy", Busy,   1'b0);
    chk("rst.err",  Err,    1'b0);
    Rst = 1'b0;

    // Single request from requester 0
    Req  = 4'b0001;
    Data = 16'h0006;
    txn("single", 4'b0001, 4'h6, 1'b0, 0);
    Req = '0;
    idle_chk("single", 4'h6);

    // Fresh reset so rotation starts at requester 0
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;

    // Round robin with all four requesting
    Req  = 4'b1111;
    Data = 16'h4662;
    txn("rr0", 4'b0001, 4'h2, 1'b0, 0);
    idle_chk("rr0", 4'h2);
    txn("rr1", 4'b0010, 4'h6, 1'b0, 0);
    idle_chk("rr1", 4'h6);
    txn("rr2", 4'b0100, 4'h6, 1'b0, 0);
    idle_chk("rr2", 4'h6);
    txn("rr3", 4'b1000, 4'h4, 1'b0, 0);
    idle_chk("rr3", 4'h4);
    txn("rr4", 4'b0001, 4'h2, 1'b0, 0);
    Req = '0;
    idle_chk("rr4", 4'h2);

    // Data change after grant is ignored
    Req  = 4'b0010;
    Data = 16'h0060;
    txn("dchg", 4'b0010, 4'h6, 1'b0, 1);
    Req = '0;
    idle_chk("dchg", 4'h6);

    // Req[2] dropped during ENABLE: still completes, no regrant
    Req  = 4'b0100;
    Data = 16'h0500;
    txn("drop", 4'b0100, 4'h5, 1'b0, 2);
    idle_chk("drop.a", 4'h5);
    idle_chk("drop.b", 4'h5);

    // Readback with latch Q stuck at zero
    stuck = 1'b1;
    Req   = 4'b0001;
    Data  = 16'h0004;
    txn("stuck", 4'b0001, 4'h4, exp_stuck_err, 0);
    Req = '0;
    idle_chk("stuck", 4'h4);
    @(negedge Clk);
    chk("stuck.err.clr", Err, 1'b0);
    stuck = 1'b0;

    // Async reset during ENABLE: last=0 so requester 1 wins first
    Req  = 4'b1111;
    Data = 16'h4662;
    @(negedge Clk);
    chk("arst.pre.gnt", Gnt, 4'b0010);
    @(negedge Clk);
    chk("arst.pre.en", En_out, 1'b1);
    #2 Rst = 1'b1;
    #1;
    chk("arst.en",   En_out, 1'b0);
    chk("arst.gnt",  Gnt,    '0);
    chk("arst.busy", Busy,   1'b0);
    chk("arst.done", Done,   '0);
    @(negedge Clk);
    chk("arst.hold.done", Done, '0);
    chk("arst.hold.d",    D_out, '0);
    Rst = 1'b0;
    txn("arst.next", 4'b0001, 4'h2, 1'b0, 0);
    Req = '0;
    idle_chk("arst.next", 4'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
